// File: rtl/pipe_pkg.sv
// Shared latency/depth defaults and FSM encoding for the memory-access stage.
package pipe_pkg;

    localparam int MEM_LAT_DEF     = 2;
    localparam int DEPTH_WORDS_DEF = 128;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/data_mem.sv
// Single-port word memory: synchronous write, combinational read, no reset on contents.
module data_mem #(
    parameter int DEPTH_WORDS = 128,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_access.sv
// Pipeline memory stage: stalls MEM_LAT cycles per aligned access, then registers writeback.
//  state   | meaning
//  IDLE    | no access in flight; a new request starts the wait count
//  WAIT    | counting down remaining stall cycles for the held request
module memory_access import pipe_pkg::*; #(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int MEM_LAT     = MEM_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        XM_MemtoReg,
    input  logic        XM_RegWrite,
    input  logic        XM_MemRead,
    input  logic        XM_MemWrite,
    input  logic        XM_branch,
    input  logic [31:0] ALUout,
    input  logic [31:0] XM_MD,
    input  logic [4:0]  XM_RD,
    input  logic [31:0] XM_BT,
    output logic        MW_MemtoReg,
    output logic        MW_RegWrite,
    output logic [31:0] MW_ALUout,
    output logic [31:0] MW_LMD,
    output logic [4:0]  MW_RD,
    output logic        mem_stall,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        misalign_err
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam bit         HAS_LAT = (MEM_LAT > 0);
    localparam logic [3:0] LAT_M1  = HAS_LAT ? 4'(MEM_LAT - 1) : 4'd0;

    mem_state_t  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        access, aligned, req, misalign, mem_we;
    logic [31:0] rdata;
    logic        unused_addr_hi;

    assign access   = XM_MemRead | XM_MemWrite;
    assign aligned  = (ALUout[1:0] == 2'b00);
    assign req      = access & aligned;
    assign misalign = access & ~aligned;

    assign mem_stall = req & ((state == ST_IDLE && HAS_LAT) ||
                              (state == ST_WAIT && cnt != 4'd0));

    // Gating with rst keeps a zero-latency store from landing while reset is held.
    assign mem_we = req & XM_MemWrite & ~mem_stall & rst;

    assign branch_taken   = XM_branch & ~mem_stall;
    assign branch_target  = XM_BT;
    assign unused_addr_hi = ^ALUout[31:AW+2];

    data_mem #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (ALUout[AW+1:2]),
        .wdata (XM_MD),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (req && HAS_LAT) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = LAT_M1;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) state_nxt = ST_IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MW_MemtoReg  <= 1'b0;
            MW_RegWrite  <= 1'b0;
            MW_ALUout    <= 32'd0;
            MW_LMD       <= 32'd0;
            MW_RD        <= 5'd0;
            misalign_err <= 1'b0;
        end else begin
            if (misalign) misalign_err <= 1'b1;
            if (mem_stall) begin
                MW_MemtoReg <= 1'b0;
                MW_RegWrite <= 1'b0;
            end else begin
                // A misaligned access retires as a bubble so nothing is written back.
                MW_MemtoReg <= XM_MemtoReg & ~misalign;
                MW_RegWrite <= XM_RegWrite & ~misalign;
                MW_ALUout   <= ALUout;
                MW_RD       <= XM_RD;
                if (req && XM_MemRead) MW_LMD <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access at default MEM_LAT=2, DEPTH_WORDS=128.
module tb_memory_access;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch;
    logic [31:0] ALUout, XM_MD, XM_BT;
    logic [4:0]  XM_RD;
    logic        MW_MemtoReg, MW_RegWrite, mem_stall, branch_taken, misalign_err;
    logic [31:0] MW_ALUout, MW_LMD, branch_target;
    logic [4:0]  MW_RD;

    int errors = 0;
    int checks = 0;
    int stalls;

    memory_access dut (
        .clk(clk), .rst(rst),
        .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
        .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite), .XM_branch(XM_branch),
        .ALUout(ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD), .XM_BT(XM_BT),
        .MW_MemtoReg(MW_MemtoReg), .MW_RegWrite(MW_RegWrite),
        .MW_ALUout(MW_ALUout), .MW_LMD(MW_LMD), .MW_RD(MW_RD),
        .mem_stall(mem_stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [31:0] addr, input logic [31:0] md, input logic [4:0] rdst);
        XM_MemRead  = rd;
        XM_MemWrite = wr;
        XM_MemtoReg = m2r;
        XM_RegWrite = rw;
        ALUout      = addr;
        XM_MD       = md;
        XM_RD       = rdst;
        XM_branch   = 1'b0;
        XM_BT       = 32'd0;
    endtask

    // Drives one op at a negedge, counts stall cycles, lets it retire, then idles inputs.
    task automatic run_op(input logic rd, input logic wr, input logic m2r, input logic rw,
                          input logic [31:0] addr, input logic [31:0] md, input logic [4:0] rdst,
                          output int n_stall);
        @(negedge clk);
        drive(rd, wr, m2r, rw, addr, md, rdst);
        n_stall = 0;
        #1;
        while (mem_stall && n_stall < 20) begin
            n_stall++;
            @(negedge clk);
            #1;
        end
        if (n_stall >= 20) chk("stall_timeout", 32'(n_stall), 32'd2);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        #12;
        chk("rst_regwrite", 32'(MW_RegWrite), 32'd0);
        chk("rst_aluout", MW_ALUout, 32'd0);
        chk("rst_lmd", MW_LMD, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h1234_5678, 5'd0, stalls);
        chk("prestore_stalls", 32'(stalls), 32'd2);

        // Store 0xDEADBEEF to 0x10 with a branch pending: two stalls, write on third edge.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0);
        XM_branch = 1'b1;
        XM_BT     = 32'h80;
        #1;
        chk("st_stall1", 32'(mem_stall), 32'd1);
        chk("st_br_blocked", 32'(branch_taken), 32'd0);
        chk("st_mem_old1", dut.u_mem.mem[4], 32'h1234_5678);
        @(negedge clk); #1;
        chk("st_stall2", 32'(mem_stall), 32'd1);
        chk("st_mem_old2", dut.u_mem.mem[4], 32'h1234_5678);
        @(negedge clk); #1;
        chk("st_stall3", 32'(mem_stall), 32'd0);
        chk("st_br_free", 32'(branch_taken), 32'd1);
        @(posedge clk); #1;
        chk("st_mem_new", dut.u_mem.mem[4], 32'hDEAD_BEEF);
        chk("st_regwrite", 32'(MW_RegWrite), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);

        run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'd0, 5'd5, stalls);
        chk("ld_stalls", 32'(stalls), 32'd2);
        chk("ld_lmd", MW_LMD, 32'hDEAD_BEEF);
        chk("ld_rd", 32'(MW_RD), 32'd5);
        chk("ld_memtoreg", 32'(MW_MemtoReg), 32'd1);
        chk("ld_regwrite", 32'(MW_RegWrite), 32'd1);

        run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'd0, 5'd6, stalls);
        chk("mis_stalls", 32'(stalls), 32'd0);
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_regwrite", 32'(MW_RegWrite), 32'd0);
        chk("mis_lmd_held", MW_LMD, 32'hDEAD_BEEF);

        // R-type with branch: one edge, no stall.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h7, 32'd0, 5'd3);
        XM_branch = 1'b1;
        XM_BT     = 32'h40;
        #1;
        chk("rt_stall", 32'(mem_stall), 32'd0);
        chk("rt_br_taken", 32'(branch_taken), 32'd1);
        chk("rt_br_target", branch_target, 32'h40);
        @(posedge clk); #1;
        chk("rt_aluout", MW_ALUout, 32'h7);
        chk("rt_rd", 32'(MW_RD), 32'd3);
        chk("rt_regwrite", 32'(MW_RegWrite), 32'd1);
        chk("rt_lmd_held", MW_LMD, 32'hDEAD_BEEF);
        chk("mis_sticky", 32'(misalign_err), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);

        run_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h1111_1111, 5'd0, stalls);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'd0, 5'd7, stalls);
        chk("wrap_lmd", MW_LMD, 32'h1111_1111);

        run_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'hCAFE_0000, 5'd9, stalls);
        chk("pre_rst_aluout", MW_ALUout, 32'h20);

        // Reset pulse during the first stall cycle of a store of 0x5 to 0x20.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h5, 5'd9);
        #1;
        chk("abort_stall", 32'(mem_stall), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_regwrite", 32'(MW_RegWrite), 32'd0);
        chk("abort_memtoreg", 32'(MW_MemtoReg), 32'd0);
        chk("abort_aluout", MW_ALUout, 32'd0);
        chk("abort_lmd", MW_LMD, 32'd0);
        chk("abort_rd", 32'(MW_RD), 32'd0);
        chk("abort_misalign", 32'(misalign_err), 32'd0);
        chk("abort_state", 32'(dut.state), 32'(ST_IDLE));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_mem8", dut.u_mem.mem[8], 32'hCAFE_0000);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'd0, 5'd4, stalls);
        chk("abort_ld_lmd", MW_LMD, 32'hCAFE_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
